// File: rtl/mem_access_unit.sv
// Load/store stage: turns an ALU effective address plus rt into one data-memory
// transaction and returns the formatted load value or a store completion.
module mem_access_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_wen,
   output logic [3:0]            mem_strb,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rdata_valid,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_addr_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t      r_state;
   logic [3:0]  r_op;
   logic [1:0]  r_n;
   logic [31:0] r_rt;
   logic        w_misalign;
   logic        w_undef;

   function automatic logic [31:0] load_fmt(input logic [3:0] op, input logic [1:0] n,
                                            input logic [31:0] rd, input logic [31:0] rt);
      logic [31:0] sh;
      logic [15:0] h;
      sh = rd >> {n, 3'b000};
      h  = n[1] ? rd[31:16] : rd[15:0];
      case (op)
         4'd0:    return {{24{sh[7]}}, sh[7:0]};
         4'd4:    return {24'h0, sh[7:0]};
         4'd1:    return {{16{h[15]}}, h};
         4'd5:    return {16'h0, h};
         // LWL/LWR: memory bytes replace one end of rt, the rest of rt survives
         4'd2:    return (rd << {~n, 3'b000}) | (rt & (32'h00FF_FFFF >> {n, 3'b000}));
         4'd6:    return sh | (rt & ~(32'hFFFF_FFFF >> {n, 3'b000}));
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] st_strb(input logic [3:0] op, input logic [1:0] n);
      case (op)
         4'd8:    return 4'b0001 << n;
         4'd9:    return n[1] ? 4'b1100 : 4'b0011;
         4'd11:   return 4'b1111;
         4'd10:   return 4'b1111 >> ~n;
         4'd14:   return 4'b1111 << n;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] st_data(input logic [3:0] op, input logic [1:0] n,
                                           input logic [31:0] rt);
      case (op)
         4'd8:    return {4{rt[7:0]}};
         4'd9:    return {2{rt[15:0]}};
         4'd11:   return rt;
         4'd10:   return rt >> {~n, 3'b000};
         4'd14:   return rt << {n, 3'b000};
         default: return 32'h0;
      endcase
   endfunction

   always_comb begin
      w_misalign = 1'b0;
      case (req_op)
         4'd1, 4'd5, 4'd9: w_misalign = req_addr[0];
         4'd3, 4'd11:      w_misalign = |req_addr[1:0];
         default:          w_misalign = 1'b0;
      endcase
   end

   assign w_undef   = req_op inside {4'd7, 4'd12, 4'd13, 4'd15};
   assign req_ready = (r_state == S_IDLE) && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_op          <= 4'd0;
         r_n           <= 2'd0;
         r_rt          <= 32'h0;
         mem_req_valid <= 1'b0;
         mem_addr      <= '0;
         mem_wen       <= 1'b0;
         mem_strb      <= 4'b0000;
         mem_wdata     <= '0;
         resp_valid    <= 1'b0;
         resp_data     <= '0;
         resp_addr_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_op <= req_op;
                  r_n  <= req_addr[1:0];
                  r_rt <= req_wdata;
                  if (w_misalign || w_undef) begin
                     resp_valid    <= 1'b1;
                     resp_data     <= '0;
                     resp_addr_err <= w_misalign;
                     r_state       <= S_RESP;
                  end else begin
                     mem_req_valid <= 1'b1;
                     mem_addr      <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                     mem_wen       <= req_op[3];
                     mem_strb      <= st_strb(req_op, req_addr[1:0]);
                     mem_wdata     <= st_data(req_op, req_addr[1:0], req_wdata);
                     r_state       <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  if (mem_wen) begin
                     resp_valid    <= 1'b1;
                     resp_data     <= '0;
                     resp_addr_err <= 1'b0;
                     r_state       <= S_RESP;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (mem_rdata_valid) begin
                  resp_valid    <= 1'b1;
                  resp_data     <= load_fmt(r_op, r_n, mem_rdata, r_rt);
                  resp_addr_err <= 1'b0;
                  r_state       <= S_RESP;
               end
            end
            S_RESP: begin
               resp_valid    <= 1'b0;
               resp_data     <= '0;
               resp_addr_err <= 1'b0;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random transactions checked against a
// byte-lane reference model of the load/store rules.
module tb_mem_access_unit;

   logic        clk, rst;
   logic        req_valid, req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        mem_req_valid, mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [3:0]  mem_strb;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_rdata_valid;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_addr_err;

   int n_total = 0;
   int n_bad   = 0;

   mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_strb(mem_strb),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_addr_err(resp_addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // kind: 0 load, 1 store, 2 misaligned, 3 undefined
   task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] rd, output int kind, output logic [31:0] edata,
                        output logic [3:0] estrb, output logic [31:0] ewd);
      logic [7:0] m[4];
      logic [7:0] r[4];
      logic [7:0] res[4];
      logic [7:0] wl[4];
      int n;
      bit sx;
      n = int'(addr[1:0]);
      for (int i = 0; i < 4; i++) begin
         m[i] = rd[8*i +: 8];
         r[i] = rt[8*i +: 8];
         res[i] = 8'h00;
         wl[i] = 8'h00;
      end
      kind = 0; estrb = 4'b0000; edata = 32'h0; ewd = 32'h0;
      case (op)
         4'd0, 4'd4: begin
            res[0] = m[n];
            sx = (op == 4'd0) && m[n][7];
            for (int i = 1; i < 4; i++) res[i] = sx ? 8'hFF : 8'h00;
         end
         4'd1, 4'd5: begin
            if (addr[0]) kind = 2;
            else begin
               res[0] = m[n]; res[1] = m[n+1];
               sx = (op == 4'd1) && m[n+1][7];
               res[2] = sx ? 8'hFF : 8'h00; res[3] = res[2];
            end
         end
         4'd3: begin
            if (n != 0) kind = 2;
            else for (int i = 0; i < 4; i++) res[i] = m[i];
         end
         4'd2: for (int i = 0; i < 4; i++) res[i] = (i >= 3 - n) ? m[i-3+n] : r[i];
         4'd6: for (int i = 0; i < 4; i++) res[i] = (i + n <= 3) ? m[i+n] : r[i];
         4'd8: begin
            kind = 1; estrb[n] = 1'b1;
            for (int i = 0; i < 4; i++) wl[i] = r[0];
         end
         4'd9: begin
            if (addr[0]) kind = 2;
            else begin
               kind = 1; estrb[n] = 1'b1; estrb[n+1] = 1'b1;
               for (int i = 0; i < 4; i++) wl[i] = r[i%2];
            end
         end
         4'd11: begin
            if (n != 0) kind = 2;
            else begin
               kind = 1; estrb = 4'b1111;
               for (int i = 0; i < 4; i++) wl[i] = r[i];
            end
         end
         4'd10: begin
            kind = 1;
            for (int i = 0; i <= n; i++) begin estrb[i] = 1'b1; wl[i] = r[i+3-n]; end
         end
         4'd14: begin
            kind = 1;
            for (int i = n; i < 4; i++) begin estrb[i] = 1'b1; wl[i] = r[i-n]; end
         end
         default: kind = 3;
      endcase
      for (int i = 0; i < 4; i++) begin
         edata[8*i +: 8] = res[i];
         ewd[8*i +: 8]   = wl[i];
      end
      if (kind != 0) edata = 32'h0;
      if (kind >= 2) estrb = 4'b0000;
   endtask

   task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] rd, input int rdy_dly, input int rd_dly,
                          input string nm);
      int kind, hs_cyc, resp_cyc, nreq, nresp, first_req, exp_lat;
      logic [31:0] edata, ewd;
      logic [3:0]  estrb;
      model(op, addr, rt, rd, kind, edata, estrb, ewd);
      hs_cyc = -1; resp_cyc = -1; nreq = 0; nresp = 0; first_req = -1;
      @(negedge clk);
      chk({nm, ".ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = rt;
      for (int cyc = 1; cyc < 40; cyc++) begin
         @(negedge clk);
         req_valid = 1'b0; req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
         mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = $urandom;
         if (mem_req_valid) begin
            if (first_req < 0) first_req = cyc;
            chk({nm, ".addr"}, mem_addr, addr & 32'hFFFF_FFFC);
            chk({nm, ".wen"}, 32'(mem_wen), 32'(kind == 1));
            chk({nm, ".strb"}, 32'(mem_strb), 32'(estrb));
            if (kind == 1) chk({nm, ".wdata"}, mem_wdata, ewd);
            if (nreq == rdy_dly) begin
               mem_req_ready = 1'b1;
               hs_cyc = cyc;
            end else begin
               mem_rdata_valid = 1'($urandom);
            end
            nreq++;
         end
         if (kind == 0 && hs_cyc >= 0 && cyc == hs_cyc + rd_dly) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = rd;
         end
         if (resp_valid) begin
            nresp++;
            if (resp_cyc < 0) resp_cyc = cyc;
            chk({nm, ".data"}, resp_data, edata);
            chk({nm, ".err"}, 32'(resp_addr_err), 32'(kind == 2));
         end
         if (resp_cyc >= 0 && cyc > resp_cyc) break;
      end
      mem_req_ready = 1'b0; mem_rdata_valid = 1'b0;
      chk({nm, ".nresp"}, nresp, 32'd1);
      if (kind >= 2)      exp_lat = 1;
      else if (kind == 1) exp_lat = hs_cyc + 1;
      else                exp_lat = hs_cyc + rd_dly + 1;
      chk({nm, ".lat"}, resp_cyc, exp_lat);
      if (kind < 2) begin
         chk({nm, ".first_req"}, first_req, 32'd1);
         chk({nm, ".nreq"}, nreq, rdy_dly + 1);
      end else begin
         chk({nm, ".nreq"}, nreq, 32'd0);
      end
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, ".mreqv"}, 32'(mem_req_valid), 32'd0);
      chk({nm, ".maddr"}, mem_addr, 32'd0);
      chk({nm, ".wen"}, 32'(mem_wen), 32'd0);
      chk({nm, ".strb"}, 32'(mem_strb), 32'd0);
      chk({nm, ".wdata"}, mem_wdata, 32'd0);
      chk({nm, ".respv"}, 32'(resp_valid), 32'd0);
      chk({nm, ".rdata"}, resp_data, 32'd0);
      chk({nm, ".err"}, 32'(resp_addr_err), 32'd0);
      chk({nm, ".ready"}, 32'(req_ready), 32'd0);
   endtask

   task automatic reset_mid_wait();
      @(negedge clk);
      chk("rstw.ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = 4'd3; req_addr = 32'h0000_4000; req_wdata = 32'h0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstw.reqv", 32'(mem_req_valid), 32'd1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("rstw.wait_addr", mem_addr, 32'h0000_4000);
      #2 rst = 1'b1;
      #1 check_all_zero("rstw");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rstw.ready_after", 32'(req_ready), 32'd1);
      mem_rdata_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      repeat (4) begin
         @(negedge clk);
         mem_rdata_valid = 1'b0;
         chk("rstw.no_resp", 32'(resp_valid), 32'd0);
      end
   endtask

   task automatic back_to_back();
      int second_acc, resp1, resp2;
      second_acc = -1; resp1 = -1; resp2 = -1;
      @(negedge clk);
      chk("b2b.ready0", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = 4'd11; req_addr = 32'h0000_5000; req_wdata = 32'hCAFE_F00D;
      mem_req_ready = 1'b1;
      for (int cyc = 1; cyc < 10; cyc++) begin
         @(negedge clk);
         mem_rdata_valid = 1'b0;
         if (cyc == 1) begin req_op = 4'd3; req_addr = 32'h0000_5004; end
         if (req_valid && req_ready && second_acc < 0) second_acc = cyc;
         else if (second_acc >= 0) req_valid = 1'b0;
         if (second_acc >= 0 && cyc == second_acc + 2) begin
            mem_rdata_valid = 1'b1; mem_rdata = 32'h1234_5678;
         end
         if (resp_valid) begin
            if (resp1 < 0) begin
               resp1 = cyc;
               chk("b2b.sw_data", resp_data, 32'h0);
            end else if (resp2 < 0) begin
               resp2 = cyc;
               chk("b2b.lw_data", resp_data, 32'h1234_5678);
            end
         end
      end
      req_valid = 1'b0; mem_req_ready = 1'b0; mem_rdata_valid = 1'b0;
      chk("b2b.resp1", resp1, 32'd2);
      chk("b2b.accept2", second_acc, 32'd3);
      chk("b2b.resp2", resp2, 32'd6);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'h0; req_wdata = 32'h0;
      mem_req_ready = 1'b0; mem_rdata = 32'h0; mem_rdata_valid = 1'b0;
      #1 rst = 1'b1;
      #1 check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_txn(4'd0,  32'h0000_1003, 32'h0,         32'h80FF_1234, 0, 1, "lb");
      run_txn(4'd4,  32'h0000_1003, 32'h0,         32'h80FF_1234, 0, 1, "lbu");
      run_txn(4'd9,  32'h0000_2002, 32'hDEAD_BEEF, 32'h0,         3, 1, "sh_stall");
      run_txn(4'd3,  32'h0000_3001, 32'h0,         32'h0,         0, 1, "lw_mis");
      run_txn(4'd9,  32'h0000_3001, 32'h0,         32'h0,         0, 1, "sh_mis");
      run_txn(4'd2,  32'h0000_0101, 32'h1122_3344, 32'hAABB_CCDD, 1, 2, "lwl");
      run_txn(4'd6,  32'h0000_0101, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, "lwr");
      run_txn(4'd10, 32'h0000_0102, 32'h1122_3344, 32'h0,         0, 1, "swl");
      run_txn(4'd14, 32'h0000_0102, 32'h1122_3344, 32'h0,         2, 1, "swr");
      run_txn(4'd13, 32'h0000_0100, 32'h1122_3344, 32'h0,         0, 1, "undef");
      run_txn(4'd11, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,         0, 1, "sw");

      reset_mid_wait();
      back_to_back();

      for (int t = 0; t < 200; t++) begin
         run_txn(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), "rnd");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the ALU. It takes the ALU result as the effective address, plus the rt value and the memory opcode.
- Runs one data-memory transaction over a valid/ready handshake.
- Returns the extended or merged load result, or a store completion, toward writeback.
- Little-endian. Handles byte, half and word accesses, LWL/LWR/SWL/SWR, and misaligned-address detection.

Parameters:
- ADDR_WIDTH, 32, width of effective address and mem_addr.
- DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  upstream request valid
- req_ready  output  1  unit can accept a request
- req_op  input  4  memory opcode, equal to instruction opcode[3:0]: 0 LB, 1 LH, 2 LWL, 3 LW, 4 LBU, 5 LHU, 6 LWR, 8 SB, 9 SH, 10 SWL, 11 SW, 14 SWR
- req_addr  input  ADDR_WIDTH  effective address (ALU Result)
- req_wdata  input  32  rt value; store data, and old rt for LWL/LWR merge
- mem_req_valid  output  1  memory request valid
- mem_req_ready  input  1  memory accepts request
- mem_addr  output  ADDR_WIDTH  word-aligned address, {req_addr[31:2],2'b00}
- mem_wen  output  1  1 = write, 0 = read
- mem_strb  output  4  byte write strobes; 0000 on reads
- mem_wdata  output  32  lane-aligned write data
- mem_rdata  input  32  read data
- mem_rdata_valid  input  1  read data valid, one-cycle pulse
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  32  value for rt; 0 for stores and errors
- resp_addr_err  output  1  misaligned address, qualifies resp_valid

Behaviour:
- Reset:
  - rst high asynchronously forces state IDLE.
  - Clears every registered output and latch: mem_req_valid, mem_wen, mem_strb, mem_addr, mem_wdata, resp_valid, resp_data, resp_addr_err all 0.
  - req_ready is 0 while rst is high.
- States: IDLE, REQ, WAIT, RESP. req_ready = 1 only in IDLE.
- IDLE:
  - On req_valid & req_ready, latch op, addr, wdata.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) -> RESP with addr_err=1, no memory access.
  - Undefined op (7, 12, 13, 15) -> RESP with data 0, addr_err=0, no memory access.
  - Otherwise -> REQ.
- REQ:
  - mem_req_valid=1; addr, wen, strb, wdata held stable until mem_req_ready.
  - On ready: store -> RESP; load -> WAIT.
- WAIT: on mem_rdata_valid, capture the formatted result -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. No stall input; downstream must take the pulse.
- mem_rdata_valid is ignored outside WAIT. Memory must not assert it in the same cycle as the mem_req_ready handshake.
- Latency: accept at cycle 0. Zero-wait store responds at cycle 2. Load with rdata at cycle 2 responds at cycle 3. Error/undefined responds at cycle 1.
- Load formatting, with n = addr[1:0] and byte k = mem_rdata[8k+7:8k]:
  - LB/LBU: byte n, sign/zero extended.
  - LH/LHU: half selected by n[1], sign/zero extended.
  - LW: whole word.
  - LWL: (mem_rdata << 8*(3-n)) | (rt & low (3-n) bytes mask).
  - LWR: (mem_rdata >> 8*n) | (rt & high n bytes mask).
- Store formatting:
  - SB: strb = 1<<n, data = {4{rt[7:0]}}.
  - SH: strb = n[1] ? 1100 : 0011, data = {2{rt[15:0]}}.
  - SW: strb 1111, data rt.
  - SWL: strb = (1<<(n+1))-1, data = rt >> 8*(3-n).
  - SWR: strb = (1111<<n)[3:0], data = rt << 8*n.
- Reset mid-transaction: abandon it, return to IDLE, emit no resp_valid. A late mem_rdata_valid is ignored.
- Inputs changing after acceptance have no effect; only the latched copies are used.

Test Plan:
- Reset: rst pulse asynchronously in WAIT -> all outputs 0 immediately; after release req_ready=1; a later mem_rdata_valid produces no resp_valid.
- LB sign extension: addr 0x1003, mem_rdata 0x80FF_1234, ready every cycle, rdata one cycle after the handshake -> resp_data 0xFFFF_FF80, resp_valid at cycle 3. LBU at the same address -> 0x0000_0080.
- SH: addr 0x2002, rt 0xDEAD_BEEF, mem_req_ready delayed 3 cycles -> mem_addr 0x2000, strb 1100, wdata 0xBEEF_BEEF, all held stable across the stall; then one resp_valid with data 0.
- Misaligned: LW at 0x3001 -> resp_valid at cycle 1, resp_addr_err=1, mem_req_valid never asserted. SH at 0x3001 -> same.
- LWL/LWR: rt 0x1122_3344, mem_rdata 0xAABB_CCDD, n=1:
  - LWL -> 0xCCDD_3344.
  - LWR -> 0x11AA_BBCC.
- SWL/SWR: rt 0x1122_3344, n=2:
  - SWL -> strb 0111, wdata 0x0011_2233.
  - SWR -> strb 1100, wdata 0x3344_0000.
- Back-to-back: SW then LW issued with req_valid held high -> second request accepted only on the cycle after the first resp_valid.
